// File: rtl/stch_to_dec_pkg.sv
// Shared definitions for the stochastic-to-decimal decoder.
//   state_t    : FSM state encoding (IDLE waits for START, ACC accumulates)
//   ND_DEFAULT : default result width; a window is 2^ND qualified samples
package stch_to_dec_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  localparam int ND_DEFAULT = 8;

endpackage

// File: rtl/stch_win_cnt.sv
// Window counters for the stochastic decoder.
// Counts qualified samples and the ones among them, and flags the sample
// that closes a window together with the saturated ones count for it.
// Ports:
//   CLK    - clock, rising edge
//   INIT   - synchronous active-high reset
//   clr    - clear both counters (window start from IDLE)
//   inc    - qualified sample this cycle
//   s      - stochastic bit of the current sample
//   last   - this qualified sample closes the window
//   result - ones count including the current sample, saturated to ND bits
module stch_win_cnt
  import stch_to_dec_pkg::*;
#(
  parameter int ND = ND_DEFAULT
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          clr,
  input  logic          inc,
  input  logic          s,
  output logic          last,
  output logic [ND-1:0] result
);

  localparam logic [ND-1:0] SAMP_MAX = {ND{1'b1}};

  logic [ND-1:0] samp_r;
  logic [ND:0]   ones_r;
  logic [ND:0]   ones_nxt_s;

  // A full window of ones (2^ND) does not fit in ND bits; clamp to all-ones.
  function automatic logic [ND-1:0] sat_count(input logic [ND:0] cnt);
    logic [ND-1:0] res;
    if (cnt[ND]) begin
      res = {ND{1'b1}};
    end else begin
      res = cnt[ND-1:0];
    end
    return res;
  endfunction

  // Ones count including the sample presented this cycle.
  always_comb begin
    ones_nxt_s = ones_r + {{ND{1'b0}}, s};
    last       = inc && (samp_r == SAMP_MAX);
    result     = sat_count(ones_nxt_s);
  end

  // Sample and ones counters; the window-closing sample clears both so the
  // sample counter never wraps on its own.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      samp_r <= {ND{1'b0}};
      ones_r <= {(ND+1){1'b0}};
    end else if (clr) begin
      samp_r <= {ND{1'b0}};
      ones_r <= {(ND+1){1'b0}};
    end else if (inc) begin
      if (samp_r == SAMP_MAX) begin
        samp_r <= {ND{1'b0}};
        ones_r <= {(ND+1){1'b0}};
      end else begin
        samp_r <= samp_r + {{(ND-1){1'b0}}, 1'b1};
        ones_r <= ones_nxt_s;
      end
    end else begin
      samp_r <= samp_r;
      ones_r <= ones_r;
    end
  end

endmodule

// File: rtl/stch_to_dec.sv
// Stochastic bit-stream to binary decoder.
// Counts ones over windows of 2^ND qualified samples and presents the count
// as D (probability scaled by 2^ND) with a VALID/READY handshake.
// Ports:
//   CLK   - clock, rising edge
//   INIT  - synchronous active-high reset
//   START - begin accumulation when idle (ignored while accumulating)
//   EN    - sample qualifier for S
//   S     - stochastic bit stream
//   READY - consumer accepts D when READY and VALID are both high
//   D     - decoded result
//   VALID - D holds an unconsumed result
//   BUSY  - accumulating
//   OVF   - sticky: an unconsumed result was overwritten
module stch_to_dec
  import stch_to_dec_pkg::*;
#(
  parameter int ND   = ND_DEFAULT,
  parameter bit CONT = 1'b1
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          START,
  input  logic          EN,
  input  logic          S,
  input  logic          READY,
  output logic [ND-1:0] D,
  output logic          VALID,
  output logic          BUSY,
  output logic          OVF
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic          clr_s;
  logic          inc_s;
  logic          last_s;
  logic [ND-1:0] result_s;
  logic [ND-1:0] d_r;
  logic          valid_r;
  logic          busy_r;
  logic          ovf_r;

  stch_win_cnt #(
    .ND (ND)
  ) u_win_cnt (
    .CLK    (CLK),
    .INIT   (INIT),
    .clr    (clr_s),
    .inc    (inc_s),
    .s      (S),
    .last   (last_s),
    .result (result_s)
  );

  // Next-state logic and counter controls.
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_nxt_s = ST_ACC;
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        inc_s = EN;
        // Continuous mode rolls straight into the next window.
        if (last_s && !CONT) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register with BUSY registered alongside it.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_ACC);
    end
  end

  // Result register and handshake. A load always wins over consumption;
  // overflow is flagged only when the overwritten result was not accepted.
  always_ff @(posedge CLK) begin
    if (INIT) begin
      d_r     <= {ND{1'b0}};
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (last_s) begin
      d_r     <= result_s;
      valid_r <= 1'b1;
      if (valid_r && !READY) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end else if (valid_r && READY) begin
      d_r     <= d_r;
      valid_r <= 1'b0;
      ovf_r   <= ovf_r;
    end else begin
      d_r     <= d_r;
      valid_r <= valid_r;
      ovf_r   <= ovf_r;
    end
  end

  assign D     = d_r;
  assign VALID = valid_r;
  assign BUSY  = busy_r;
  assign OVF   = ovf_r;

endmodule
